// File: rtl/scu_dma_multi_if.sv
// Register port, memory master port and per-channel IRQs of scu_dma_multi.
// slave = DMA engine side; master = CPU/memory environment side.
interface scu_dma_multi_if #(
   parameter int NCH = 3,
   parameter int AW  = 27
);
   logic [$clog2(NCH)+2:0] A;
   logic [31:0]            DI;
   logic [31:0]            DO;
   logic [3:0]             WR;
   logic                   RD;
   logic [AW-1:0]          MEM_A;
   logic [31:0]            MEM_DO;
   logic [31:0]            MEM_DI;
   logic                   MEM_RD;
   logic                   MEM_WR;
   logic                   MEM_ACK;
   logic [NCH-1:0]         IRQ;

   modport slave (
      input  A, DI, WR, RD, MEM_DI, MEM_ACK,
      output DO, MEM_A, MEM_DO, MEM_RD, MEM_WR, IRQ
   );

   modport master (
      output A, DI, WR, RD, MEM_DI, MEM_ACK,
      input  DO, MEM_A, MEM_DO, MEM_RD, MEM_WR, IRQ
   );
endinterface

// File: rtl/scu_dma_multi.sv
// NCH-channel DMA, highest pending index wins in IDLE; START->MEM_RD 2 CE_R cycles, MEM_RD/MEM_WR held until MEM_ACK.
// Optional SCU_DMA_STATUS_EN: STATUS reg reads {done, busy}; otherwise reads 0 and the done flag is absent.
module scu_dma_multi #(
   parameter int NCH = 3,
   parameter int AW  = 27,
   parameter int CW  = 20
) (
   input  logic           CLK,
   input  logic           RST_N,
   input  logic           CE_R,
   input  logic           CE_F,
   scu_dma_multi_if.slave bus
);
   localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int AXW  = $clog2(NCH) + 3;
   localparam int CNTW = CW + 1;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;

   state_e          state_q, state_d;

   logic [AW-1:0]   raddr_q [NCH];
   logic [AW-1:0]   raddr_d [NCH];
   logic [AW-1:0]   waddr_q [NCH];
   logic [AW-1:0]   waddr_d [NCH];
   logic [CW-1:0]   count_q [NCH];
   logic [CW-1:0]   count_d [NCH];
   logic [2:0]      wadd_q  [NCH];
   logic [2:0]      wadd_d  [NCH];
   logic [NCH-1:0]  radd_q, radd_d;
   logic [NCH-1:0]  en_q, en_d;
   logic [NCH-1:0]  pend_q, pend_d;
`ifdef SCU_DMA_STATUS_EN
   logic [NCH-1:0]  done_q, done_d;
`endif
   logic [CHW-1:0]  act_q, act_d, sel;
   logic [AW-1:0]   ra_q, ra_d, wa_q, wa_d;
   logic [AW-1:0]   rinc, winc;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [31:0]     dat_q, dat_d;
   logic [31:0]     do_q, do_d;
   logic [31:0]     rd_val;

   logic [2:0]      reg_sel;
   logic [AXW-1:0]  a_ch;
   logic [CHW-1:0]  ch_sel;
   logic            ch_ok;
   logic            wr_fire;
   logic            en_new;
   logic            mem_rd, mem_wr;
   logic [AW-1:0]   mem_a;
   logic [NCH-1:0]  irq;
   logic            unused_ce_f;

   function automatic logic [31:0] bmerge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return r;
   endfunction

   assign unused_ce_f = CE_F;
   assign reg_sel     = bus.A[2:0];
   assign a_ch        = bus.A >> 3;
   assign ch_sel      = CHW'(a_ch);
   assign ch_ok       = int'(a_ch) < NCH;
   assign wr_fire     = CE_R && (|bus.WR) && ch_ok;

   // Later (higher) indices overwrite earlier ones: highest pending wins.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NCH; i++) begin
         if (pend_q[i]) sel = CHW'(i);
      end
   end

   // Increment codes are stable for the active channel: reg 3 is locked while busy.
   always_comb begin
      rinc = radd_q[act_q] ? AW'(4) : '0;
      winc = (wadd_q[act_q] == 3'd0) ? '0 : (AW'(1) << wadd_q[act_q]);
   end

   always_comb begin
      rd_val = '0;
      if (ch_ok) begin
         case (reg_sel)
            3'd0:    rd_val = 32'(raddr_q[ch_sel]);
            3'd1:    rd_val = 32'(waddr_q[ch_sel]);
            3'd2:    rd_val = 32'(count_q[ch_sel]);
            3'd3:    rd_val = {23'd0, radd_q[ch_sel], 5'd0, wadd_q[ch_sel]};
            3'd4:    rd_val = {23'd0, en_q[ch_sel], 8'd0};
`ifdef SCU_DMA_STATUS_EN
            3'd5:    rd_val = {30'd0, done_q[ch_sel], pend_q[ch_sel]};
`endif
            default: rd_val = '0;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      if (CE_R) begin
         case (state_q)
            S_IDLE:  if (|pend_q) state_d = S_RD;
            S_RD:    if (bus.MEM_ACK) state_d = S_WR;
            S_WR:    if (bus.MEM_ACK) state_d = (cnt_q <= CNTW'(4)) ? S_DONE : S_RD;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      raddr_d = raddr_q;
      waddr_d = waddr_q;
      count_d = count_q;
      wadd_d  = wadd_q;
      radd_d  = radd_q;
      en_d    = en_q;
      pend_d  = pend_q;
`ifdef SCU_DMA_STATUS_EN
      done_d  = done_q;
`endif
      act_d   = act_q;
      ra_d    = ra_q;
      wa_d    = wa_q;
      cnt_d   = cnt_q;
      dat_d   = dat_q;
      do_d    = do_q;
      en_new  = 1'b0;

      if (CE_R && bus.RD) do_d = rd_val;

      if (wr_fire) begin
         case (reg_sel)
            3'd0: if (!pend_q[ch_sel])
               raddr_d[ch_sel] = AW'(bmerge(32'(raddr_q[ch_sel]), bus.DI, bus.WR));
            3'd1: if (!pend_q[ch_sel])
               waddr_d[ch_sel] = AW'(bmerge(32'(waddr_q[ch_sel]), bus.DI, bus.WR));
            3'd2: if (!pend_q[ch_sel])
               count_d[ch_sel] = CW'(bmerge(32'(count_q[ch_sel]), bus.DI, bus.WR));
            3'd3: if (!pend_q[ch_sel]) begin
               if (bus.WR[1]) radd_d[ch_sel] = bus.DI[8];
               if (bus.WR[0]) wadd_d[ch_sel] = bus.DI[2:0];
            end
            3'd4: begin
               // ENABLE written in the same cycle qualifies the START.
               en_new       = bus.WR[1] ? bus.DI[8] : en_q[ch_sel];
               en_d[ch_sel] = en_new;
               if (bus.WR[0] && bus.DI[0] && en_new && !pend_q[ch_sel]) begin
                  pend_d[ch_sel] = 1'b1;
`ifdef SCU_DMA_STATUS_EN
                  done_d[ch_sel] = 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end

      if (CE_R) begin
         case (state_q)
            S_IDLE: if (|pend_q) begin
               act_d = sel;
               ra_d  = raddr_q[sel];
               wa_d  = waddr_q[sel];
               cnt_d = (count_q[sel] == '0) ? {1'b1, {CW{1'b0}}} : {1'b0, count_q[sel]};
            end
            S_RD: if (bus.MEM_ACK) dat_d = bus.MEM_DI;
            S_WR: if (bus.MEM_ACK) begin
               ra_d = ra_q + rinc;
               wa_d = wa_q + winc;
               if (cnt_q > CNTW'(4)) cnt_d = cnt_q - CNTW'(4);
            end
            S_DONE: begin
               pend_d[act_q] = 1'b0;
`ifdef SCU_DMA_STATUS_EN
               done_d[act_q] = 1'b1;
`endif
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      mem_a  = '0;
      irq    = '0;
      case (state_q)
         S_RD: begin
            mem_rd = 1'b1;
            mem_a  = {ra_q[AW-1:2], 2'b00};
         end
         S_WR: begin
            mem_wr = 1'b1;
            mem_a  = {wa_q[AW-1:2], 2'b00};
         end
         S_DONE:  irq[act_q] = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         for (int i = 0; i < NCH; i++) begin
            raddr_q[i] <= '0;
            waddr_q[i] <= '0;
            count_q[i] <= '0;
            wadd_q[i]  <= '0;
         end
         radd_q <= '0;
         en_q   <= '0;
         pend_q <= '0;
`ifdef SCU_DMA_STATUS_EN
         done_q <= '0;
`endif
         act_q  <= '0;
         ra_q   <= '0;
         wa_q   <= '0;
         cnt_q  <= '0;
         dat_q  <= '0;
         do_q   <= '0;
      end else begin
         state_q <= state_d;
         raddr_q <= raddr_d;
         waddr_q <= waddr_d;
         count_q <= count_d;
         wadd_q  <= wadd_d;
         radd_q  <= radd_d;
         en_q    <= en_d;
         pend_q  <= pend_d;
`ifdef SCU_DMA_STATUS_EN
         done_q  <= done_d;
`endif
         act_q   <= act_d;
         ra_q    <= ra_d;
         wa_q    <= wa_d;
         cnt_q   <= cnt_d;
         dat_q   <= dat_d;
         do_q    <= do_d;
      end
   end

   assign bus.DO     = do_q;
   assign bus.MEM_A  = mem_a;
   assign bus.MEM_DO = dat_q;
   assign bus.MEM_RD = mem_rd;
   assign bus.MEM_WR = mem_wr;
   assign bus.IRQ    = irq;
endmodule

// File: tb/tb_scu_dma_multi.sv
// Directed bench for scu_dma_multi (NCH=3, AW=12, CW=4); memory returns C0DE_0000|addr.
module tb_scu_dma_multi;
   localparam int NCH = 3;
   localparam int AW  = 12;
   localparam int CW  = 4;

`ifdef SCU_DMA_STATUS_EN
   localparam logic [31:0] ST_DONE = 32'h2;
   localparam logic [31:0] ST_BUSY = 32'h1;
`else
   localparam logic [31:0] ST_DONE = 32'h0;
   localparam logic [31:0] ST_BUSY = 32'h0;
`endif

`define CHK(TAG, OBS, EXP) begin total++; assert ((OBS) === (EXP)) else begin bad++; $error("FAIL %s: observed=%0h expected=%0h", TAG, OBS, EXP); end end

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;
   logic CE_R  = 1'b1;
   logic CE_F  = 1'b0;

   int total = 0;
   int bad   = 0;
   int irq_cnt [NCH];
   int irq_log [$];
   logic [31:0] rv;
   logic [31:0] d;

   scu_dma_multi_if #(.NCH(NCH), .AW(AW)) bus ();

   scu_dma_multi #(.NCH(NCH), .AW(AW), .CW(CW)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .CE_R  (CE_R),
      .CE_F  (CE_F),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      for (int i = 0; i < NCH; i++) begin
         if (bus.IRQ[i] === 1'b1) begin
            irq_cnt[i]++;
            irq_log.push_back(i);
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr_reg(input int ch, input int r, input logic [31:0] v, input logic [3:0] be);
      bus.A  = 5'(ch * 8 + r);
      bus.DI = v;
      bus.WR = be;
      tick();
      bus.WR = 4'h0;
   endtask

   task automatic rd_reg(input int ch, input int r, output logic [31:0] v);
      bus.A  = 5'(ch * 8 + r);
      bus.RD = 1'b1;
      tick();
      bus.RD = 1'b0;
      v = bus.DO;
   endtask

   function automatic logic [31:0] mdat(input logic [AW-1:0] a);
      return 32'hC0DE_0000 | 32'(a);
   endfunction

   task automatic serve_rd(input logic [AW-1:0] ra, input int dly, output logic [31:0] v);
      int n = 0;
      while (bus.MEM_RD !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      total++;
      if (n >= 40) begin
         bad++;
         $error("FAIL rd_timeout: no MEM_RD within %0d cycles (addr %0h)", n, ra);
      end
      `CHK("rd_req", bus.MEM_RD, 1'b1)
      `CHK("rd_addr", bus.MEM_A, ra)
      repeat (dly) begin
         tick();
         `CHK("rd_hold", bus.MEM_RD, 1'b1)
      end
      v = mdat(ra);
      bus.MEM_DI  = v;
      bus.MEM_ACK = 1'b1;
      tick();
      bus.MEM_ACK = 1'b0;
      bus.MEM_DI  = '0;
      `CHK("rd_drop", bus.MEM_RD, 1'b0)
   endtask

   task automatic serve_wr(input logic [AW-1:0] wa, input logic [31:0] v);
      int n = 0;
      while (bus.MEM_WR !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      total++;
      if (n >= 40) begin
         bad++;
         $error("FAIL wr_timeout: no MEM_WR within %0d cycles (addr %0h)", n, wa);
      end
      `CHK("wr_req", bus.MEM_WR, 1'b1)
      `CHK("wr_addr", bus.MEM_A, wa)
      `CHK("wr_data", bus.MEM_DO, v)
      bus.MEM_ACK = 1'b1;
      tick();
      bus.MEM_ACK = 1'b0;
   endtask

   task automatic serve_word(input logic [AW-1:0] ra, input logic [AW-1:0] wa, input int dly);
      logic [31:0] v;
      serve_rd(ra, dly, v);
      serve_wr(wa, v);
   endtask

   initial begin
      bus.A = '0; bus.DI = '0; bus.WR = '0; bus.RD = 1'b0;
      bus.MEM_DI = '0; bus.MEM_ACK = 1'b0;
      repeat (3) tick();
      total++;
      if (bus.MEM_RD !== 1'b0 || bus.MEM_WR !== 1'b0 || bus.IRQ !== 3'b000 ||
          bus.MEM_A !== 12'h000 || bus.MEM_DO !== 32'h0 || bus.DO !== 32'h0) begin
         bad++;
         $error("FAIL rst_state: MEM_RD=%0b MEM_WR=%0b IRQ=%0b MEM_A=%0h MEM_DO=%0h DO=%0h",
                bus.MEM_RD, bus.MEM_WR, bus.IRQ, bus.MEM_A, bus.MEM_DO, bus.DO);
      end
      `CHK("rst_mem_rd", bus.MEM_RD, 1'b0)
      `CHK("rst_mem_wr", bus.MEM_WR, 1'b0)
      `CHK("rst_irq", bus.IRQ, 3'b000)
      `CHK("rst_mem_a", bus.MEM_A, 12'h000)
      `CHK("rst_mem_do", bus.MEM_DO, 32'h0)
      `CHK("rst_do", bus.DO, 32'h0)
      RST_N = 1'b1;
      tick();
      rd_reg(0, 5, rv); `CHK("rst_status", rv, 32'h0)
      rd_reg(0, 0, rv); `CHK("rst_raddr", rv, 32'h0)

      // Writes without CE_R are dropped.
      CE_R = 1'b0;
      wr_reg(0, 0, 32'h55, 4'hF);
      CE_R = 1'b1;
      rd_reg(0, 0, rv); `CHK("ce_gate", rv, 32'h0)

      // Channel 0 programming, byte enables, basic 16-byte transfer.
      wr_reg(0, 0, 32'h100, 4'hF);
      wr_reg(0, 1, 32'h2FF, 4'hF);
      wr_reg(0, 1, 32'h000, 4'b0001);
      wr_reg(0, 2, 32'h10, 4'hF);
      wr_reg(0, 3, 32'h102, 4'hF);
      rd_reg(0, 1, rv); `CHK("byte_en", rv, 32'h200)
      rd_reg(0, 3, rv); `CHK("add_rb", rv, 32'h102)
      rd_reg(0, 2, rv); `CHK("count_rb", rv, 32'h0)
      wr_reg(0, 4, 32'h101, 4'h3);
      `CHK("lat_cyc1", bus.MEM_RD, 1'b0)
      tick();
      `CHK("lat_cyc2", bus.MEM_RD, 1'b1)
      serve_word(12'h100, 12'h200, 1);
      serve_word(12'h104, 12'h204, 0);
      serve_word(12'h108, 12'h208, 0);
      serve_word(12'h10C, 12'h20C, 0);
      repeat (3) tick();
      `CHK("t1_irq", irq_cnt[0], 1)
      `CHK("t1_end", bus.MEM_RD, 1'b0)
      rd_reg(0, 4, rv); `CHK("ctrl_rb", rv, 32'h100)
      rd_reg(0, 5, rv); `CHK("t1_status", rv, ST_DONE)

      // COUNT=6: residue rounds up to a second word.
      wr_reg(0, 2, 32'h6, 4'hF);
      wr_reg(0, 4, 32'h001, 4'b0001);
      serve_word(12'h100, 12'h200, 0);
      serve_word(12'h104, 12'h204, 0);
      repeat (3) tick();
      `CHK("c6_irq", irq_cnt[0], 2)
      `CHK("c6_end", bus.MEM_RD, 1'b0)

      // COUNT=0 means 2^CW bytes.
      wr_reg(0, 2, 32'h0, 4'hF);
      wr_reg(0, 4, 32'h101, 4'h3);
      serve_word(12'h100, 12'h200, 0);
      serve_word(12'h104, 12'h204, 0);
      serve_word(12'h108, 12'h208, 0);
      serve_word(12'h10C, 12'h20C, 0);
      repeat (3) tick();
      `CHK("c0_irq", irq_cnt[0], 3)
      `CHK("c0_end", bus.MEM_RD, 1'b0)

      // START with ENABLE=0 is ignored.
      wr_reg(1, 0, 32'h400, 4'hF);
      wr_reg(1, 1, 32'h500, 4'hF);
      wr_reg(1, 2, 32'h8, 4'hF);
      wr_reg(1, 3, 32'h103, 4'hF);
      wr_reg(1, 4, 32'h001, 4'h3);
      repeat (4) tick();
      `CHK("no_en_rd", bus.MEM_RD, 1'b0)
      rd_reg(1, 5, rv); `CHK("no_en_status", rv, 32'h0)

      // Ch1 busy: locked regs; ch2 and ch0 queued behind it.
      wr_reg(1, 4, 32'h101, 4'h3);
      serve_rd(12'h400, 0, d);
      rd_reg(1, 5, rv); `CHK("busy_status", rv, ST_BUSY)
      wr_reg(1, 0, 32'h300, 4'hF);
      wr_reg(0, 2, 32'h8, 4'hF);
      wr_reg(2, 0, 32'h600, 4'hF);
      wr_reg(2, 1, 32'h700, 4'hF);
      wr_reg(2, 2, 32'h4, 4'hF);
      wr_reg(2, 3, 32'h101, 4'hF);
      wr_reg(2, 4, 32'h101, 4'h3);
      wr_reg(0, 4, 32'h101, 4'h3);
      rd_reg(1, 0, rv); `CHK("busy_wr_ign", rv, 32'h400)
      serve_wr(12'h500, d);
      serve_word(12'h404, 12'h508, 0);
      serve_word(12'h600, 12'h700, 0);
      serve_word(12'h100, 12'h200, 0);
      serve_word(12'h104, 12'h204, 0);
      repeat (3) tick();
      `CHK("irq_log_len", irq_log.size(), 6)
      `CHK("irq_order_a", irq_log[3], 1)
      `CHK("irq_order_b", irq_log[4], 2)
      `CHK("irq_order_c", irq_log[5], 0)

      // Read address wraps modulo 2^AW.
      wr_reg(2, 0, 32'hFFC, 4'hF);
      wr_reg(2, 1, 32'h800, 4'hF);
      wr_reg(2, 2, 32'h8, 4'hF);
      wr_reg(2, 3, 32'h102, 4'hF);
      wr_reg(2, 4, 32'h101, 4'h3);
      serve_word(12'hFFC, 12'h800, 0);
      serve_word(12'h000, 12'h804, 0);
      repeat (3) tick();
      `CHK("wrap_irq", irq_cnt[2], 2)
      rd_reg(2, 5, rv); `CHK("wrap_status", rv, ST_DONE)

      // Reset while MEM_RD is outstanding; MEM_ACK high during reset is ignored.
      wr_reg(2, 4, 32'h101, 4'h3);
      for (int n = 0; n < 10 && bus.MEM_RD !== 1'b1; n++) tick();
      `CHK("pre_rst_rd", bus.MEM_RD, 1'b1)
      RST_N = 1'b0;
      bus.MEM_ACK = 1'b1;
      tick();
      `CHK("rst_drop_rd", bus.MEM_RD, 1'b0)
      `CHK("rst_drop_irq", bus.IRQ, 3'b000)
      tick();
      bus.MEM_ACK = 1'b0;
      RST_N = 1'b1;
      tick();
      rd_reg(2, 5, rv); `CHK("post_rst_status", rv, 32'h0)
      rd_reg(2, 0, rv); `CHK("post_rst_raddr", rv, 32'h0)
      repeat (3) tick();
      `CHK("post_rst_rd", bus.MEM_RD, 1'b0)
      `CHK("post_rst_wr", bus.MEM_WR, 1'b0)

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
